hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage core. It sits beside the ID/EX pipeline register and decides every cycle whether to freeze PC and IF/ID, inject one or two bubbles into ID/EX, or hold the whole pipe for a slow memory. It also produces the 2-bit forwarding selects that ID/EX latches with the instruction.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fwd_sel.sv | 39 +++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the core's pipeline control: forwarding selects and
// hazard-controller states.
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_EX      = 2'd1,
    FWD_MEM_ALU = 2'd2,
    FWD_MEM_LD  = 2'd3
  } fwd_e;

  typedef enum logic {
    RUN   = 1'b0,
    HOLD2 = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand dependency check against EX and MEM: forwarding select plus
// load-match flags used by the hazard logic.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] ex_wreg,
  input  logic       ex_regwrite,
  input  logic       ex_load,
  input  logic [4:0] mem_wreg,
  input  logic       mem_regwrite,
  input  logic       mem_load,
  output logic [1:0] sel,
  output logic       ex_load_match,
  output logic       mem_load_match
);

  logic src_live;
  logic ex_match;
  logic mem_match;

  // $0 is hardwired, so a write to it never creates a dependency
  assign src_live  = use_src && (src != 5'd0);
  assign ex_match  = src_live && ex_regwrite && (src == ex_wreg);
  assign mem_match = src_live && mem_regwrite && (src == mem_wreg);

  assign ex_load_match  = ex_match && ex_load;
  assign mem_load_match = mem_match && mem_load;

  always_comb begin
    sel = FWD_RF;
    if (ex_match && !ex_load)
      sel = FWD_EX;
    else if (mem_match)
      sel = mem_load ? FWD_MEM_LD : FWD_MEM_ALU;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller beside ID/EX: stalls, second bubble for load-to-branch,
// memory freeze, forwarding selects and a saturating bubble counter.
//
// state | meaning
// RUN   | normal issue; hazards evaluated each cycle
// HOLD2 | second bubble cycle of a load-to-branch hazard
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_regwrite,
  input  logic             ex_load,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_regwrite,
  input  logic             mem_load,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             stall,
  output logic             stallstall,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] bubble_cnt
);

  state_e     state;
  logic       a_ex_ld, a_mem_ld, b_ex_ld, b_mem_ld;
  logic       ex_ld, mem_ld, ex_alu;
  logic [1:0] haz_len;

  fwd_sel u_fwd_a (
    .src           (id_rs),
    .use_src       (id_use_rs),
    .ex_wreg       (ex_wreg),
    .ex_regwrite   (ex_regwrite),
    .ex_load       (ex_load),
    .mem_wreg      (mem_wreg),
    .mem_regwrite  (mem_regwrite),
    .mem_load      (mem_load),
    .sel           (fwd_a),
    .ex_load_match (a_ex_ld),
    .mem_load_match(a_mem_ld)
  );

  fwd_sel u_fwd_b (
    .src           (id_rt),
    .use_src       (id_use_rt),
    .ex_wreg       (ex_wreg),
    .ex_regwrite   (ex_regwrite),
    .ex_load       (ex_load),
    .mem_wreg      (mem_wreg),
    .mem_regwrite  (mem_regwrite),
    .mem_load      (mem_load),
    .sel           (fwd_b),
    .ex_load_match (b_ex_ld),
    .mem_load_match(b_mem_ld)
  );

  assign ex_ld  = a_ex_ld || b_ex_ld;
  assign mem_ld = a_mem_ld || b_mem_ld;
  // A non-load EX match is exactly the case where the select points at EX
  assign ex_alu = (fwd_a == FWD_EX) || (fwd_b == FWD_EX);

  always_comb begin
    haz_len = 2'd0;
    if (ex_ld && id_branch)
      haz_len = 2'd2;
    else if (ex_ld || (id_branch && (ex_alu || mem_ld)))
      haz_len = 2'd1;
  end

  assign freeze     = mem_req && !mem_ready;
  assign stall      = (state == RUN) && !freeze && (haz_len != 2'd0);
  assign stallstall = (state == HOLD2) && !freeze;
  assign pc_en      = !(freeze || stall || stallstall);
  assign ifid_en    = pc_en;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= RUN;
      bubble_cnt <= '0;
    end else begin
      case (state)
        RUN:     if (stall && haz_len == 2'd2) state <= HOLD2;
        HOLD2:   if (!freeze) state <= RUN;
        default: state <= RUN;
      endcase
      if ((stall || stallstall) && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
